// File: rtl/rect_collider.sv
// Frame-synchronous player/obstacle collision checker: one obstacle per cycle through an index port.
// Optional saturating hit counter on o_hit_cnt when RECT_COLLIDER_HITCNT_EN is defined.
module rect_collider #(
    parameter int N_OBS    = 4,
    parameter int D_WIDTH  = 640,
    parameter int D_HEIGHT = 480
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_frame,
    input  logic        i_clear,
    input  logic [11:0] i_ply_x1,
    input  logic [11:0] i_ply_x2,
    input  logic [11:0] i_ply_y1,
    input  logic [11:0] i_ply_y2,
    output logic [3:0]  o_obs_idx,
    input  logic [11:0] i_obs_x1,
    input  logic [11:0] i_obs_x2,
    input  logic [11:0] i_obs_y1,
    input  logic [11:0] i_obs_y2,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_hit,
    output logic        o_bound,
    output logic        o_hit_sticky,
    output logic        o_overrun
`ifdef RECT_COLLIDER_HITCNT_EN
    ,
    output logic [7:0]  o_hit_cnt
`endif
);

    if (N_OBS < 1 || N_OBS > 15) begin : g_bad_nobs
        $error("rect_collider: N_OBS must be 1..15");
    end
    if (D_WIDTH < 1 || D_WIDTH > 4096 || D_HEIGHT < 1 || D_HEIGHT > 4096) begin : g_bad_disp
        $error("rect_collider: display size out of 12-bit range");
    end

    localparam logic [3:0]  LAST_CYC = 4'(N_OBS);
    localparam logic [3:0]  LAST_IDX = 4'(N_OBS - 1);
    localparam logic [11:0] Y_LIMIT  = 12'(D_HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

    state_t      state, state_nx;
    logic [3:0]  cyc;
    logic [11:0] px1, px2, py1, py2;
    logic        acc;
    logic        obs_hit, bound_now, last_cyc, hit_final, set_sticky;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (i_frame) state_nx = SCAN;
            SCAN:    if (last_cyc) state_nx = REPORT;
            REPORT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Wrapped edges (x1>x2 or y1>y2) describe an off-screen obstacle; never counts as a hit.
    always_comb begin
        obs_hit = (i_obs_x1 <= i_obs_x2) && (i_obs_y1 <= i_obs_y2) &&
                  (px1 <= i_obs_x2) && (i_obs_x1 <= px2) &&
                  (py1 <= i_obs_y2) && (i_obs_y1 <= py2);
    end

    assign bound_now  = py1[11] || (py2 > Y_LIMIT);
    assign last_cyc   = (state == SCAN) && (cyc == LAST_CYC);
    // Cycle 0 of the scan has no valid obstacle data yet; the mux output lags the index by one.
    assign hit_final  = acc || ((cyc != 4'd0) && obs_hit);
    assign set_sticky = last_cyc && (hit_final || bound_now);
    assign o_busy     = (state == SCAN);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cyc       <= '0;
            px1       <= '0;
            px2       <= '0;
            py1       <= '0;
            py2       <= '0;
            acc       <= 1'b0;
            o_obs_idx <= '0;
            o_done    <= 1'b0;
            o_hit     <= 1'b0;
            o_bound   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_frame) begin
                        px1       <= i_ply_x1;
                        px2       <= i_ply_x2;
                        py1       <= i_ply_y1;
                        py2       <= i_ply_y2;
                        cyc       <= '0;
                        acc       <= 1'b0;
                        o_obs_idx <= '0;
                    end
                end
                SCAN: begin
                    cyc <= cyc + 4'd1;
                    acc <= hit_final;
                    if (cyc < LAST_IDX) o_obs_idx <= o_obs_idx + 4'd1;
                    if (last_cyc) begin
                        o_done    <= 1'b1;
                        o_hit     <= hit_final;
                        o_bound   <= bound_now;
                        o_obs_idx <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_hit_sticky <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            if (set_sticky)   o_hit_sticky <= 1'b1;
            else if (i_clear) o_hit_sticky <= 1'b0;

            if (i_frame && state != IDLE) o_overrun <= 1'b1;
            else if (i_clear)             o_overrun <= 1'b0;
        end
    end

`ifdef RECT_COLLIDER_HITCNT_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear)                                 o_hit_cnt <= '0;
        else if (state == REPORT && o_hit && o_hit_cnt != 8'hFF) o_hit_cnt <= o_hit_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_rect_collider.sv
// Directed and randomized bench for rect_collider against a rectangle-overlap reference model.
// Hit-counter checks are enabled when RECT_COLLIDER_HITCNT_EN is defined.
module tb_rect_collider;

    localparam int N  = 4;
    localparam int DH = 480;

    logic        clk = 1'b0;
    logic        i_rst_n, i_frame, i_clear;
    logic [11:0] i_ply_x1, i_ply_x2, i_ply_y1, i_ply_y2;
    logic [3:0]  o_obs_idx;
    logic [11:0] i_obs_x1, i_obs_x2, i_obs_y1, i_obs_y2;
    logic        o_busy, o_done, o_hit, o_bound, o_hit_sticky, o_overrun;
`ifdef RECT_COLLIDER_HITCNT_EN
    logic [7:0]  o_hit_cnt;
`endif

    always #5 clk = ~clk;

    rect_collider #(.N_OBS(N), .D_WIDTH(640), .D_HEIGHT(DH)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_frame(i_frame), .i_clear(i_clear),
        .i_ply_x1(i_ply_x1), .i_ply_x2(i_ply_x2), .i_ply_y1(i_ply_y1), .i_ply_y2(i_ply_y2),
        .o_obs_idx(o_obs_idx),
        .i_obs_x1(i_obs_x1), .i_obs_x2(i_obs_x2), .i_obs_y1(i_obs_y1), .i_obs_y2(i_obs_y2),
        .o_busy(o_busy), .o_done(o_done), .o_hit(o_hit), .o_bound(o_bound),
        .o_hit_sticky(o_hit_sticky), .o_overrun(o_overrun)
`ifdef RECT_COLLIDER_HITCNT_EN
        , .o_hit_cnt(o_hit_cnt)
`endif
    );

    // Obstacle table; edges appear one cycle after the index, like the real edge mux.
    logic [11:0] ox1[16], ox2[16], oy1[16], oy2[16];
    always @(posedge clk) begin
        i_obs_x1 <= ox1[o_obs_idx];
        i_obs_x2 <= ox2[o_obs_idx];
        i_obs_y1 <= oy1[o_obs_idx];
        i_obs_y2 <= oy2[o_obs_idx];
    end

    int checks = 0;
    int errors = 0;
    bit m_hit, m_bound, m_sticky, m_ovr;
    int m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit ref_hit(input int px1, input int px2, input int py1, input int py2);
        bit h = 0;
        for (int k = 0; k < N; k++) begin
            int a1 = ox1[k], a2 = ox2[k], b1 = oy1[k], b2 = oy2[k];
            if (a1 > a2 || b1 > b2) continue;
            if (px1 <= a2 && a1 <= px2 && py1 <= b2 && b1 <= py2) h = 1;
        end
        return h;
    endfunction

    function automatic bit ref_bound(input int py1, input int py2);
        return (py1 >= 2048) || (py2 >= DH);
    endfunction

    task automatic set_obs_all(input int x1, input int x2, input int y1, input int y2);
        for (int k = 0; k < 16; k++) begin
            ox1[k] = 12'(x1); ox2[k] = 12'(x2); oy1[k] = 12'(y1); oy2[k] = 12'(y2);
        end
    endtask

    task automatic set_ply(input int x1, input int x2, input int y1, input int y2);
        i_ply_x1 = 12'(x1); i_ply_x2 = 12'(x2); i_ply_y1 = 12'(y1); i_ply_y2 = 12'(y2);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        i_clear = 1'b1;
        m_sticky = 0; m_ovr = 0; m_cnt = 0;
        @(negedge clk);
        i_clear = 1'b0;
        chk("sticky_cleared", o_hit_sticky, m_sticky);
        chk("overrun_cleared", o_overrun, m_ovr);
    endtask

    // One frame: c counts cycles after the cycle in which i_frame was sampled.
    task automatic run_frame(input int ovr_at, input bit clr_with_ovr, input int rst_at);
        logic [11:0] s1, s2, s3, s4;
        bit eh, eb, aborted;
        eh = ref_hit(i_ply_x1, i_ply_x2, i_ply_y1, i_ply_y2);
        eb = ref_bound(i_ply_y1, i_ply_y2);
        s1 = i_ply_x1; s2 = i_ply_x2; s3 = i_ply_y1; s4 = i_ply_y2;
        aborted = 0;
        @(negedge clk);
        i_frame = 1'b1;
        for (int c = 1; c <= N + 2; c++) begin
            @(negedge clk);
            i_frame = 1'b0;
            i_clear = 1'b0;
            if (aborted) begin
                if (c == rst_at + 1) begin
                    chk("rst_idx", o_obs_idx, 0);
                    chk("rst_hit", o_hit, 0);
                    chk("rst_sticky", o_hit_sticky, 0);
                    i_rst_n = 1'b1;
                end
                chk("rst_busy", o_busy, 0);
                chk("rst_no_done", o_done, 0);
            end else begin
                if (c == 1) begin
                    chk("hit_held", o_hit, m_hit);
                    chk("bound_held", o_bound, m_bound);
                end
                chk("idx", o_obs_idx, (c <= N) ? c - 1 : (c == N + 1) ? N - 1 : 0);
                chk("busy", o_busy, (c <= N + 1) ? 1 : 0);
                chk("done", o_done, (c == N + 2) ? 1 : 0);
                if (c == N + 2) begin
                    chk("hit", o_hit, eh);
                    chk("bound", o_bound, eb);
                    m_hit = eh; m_bound = eb;
                    m_sticky = m_sticky | eh | eb;
                    chk("sticky", o_hit_sticky, m_sticky);
                end
            end
            if (c == 2) set_ply($urandom_range(0, 4095), $urandom_range(0, 4095),
                                $urandom_range(0, 4095), $urandom_range(0, 4095));
            if (c == ovr_at) begin
                i_frame = 1'b1;
                m_ovr = 1;
                if (clr_with_ovr) begin
                    i_clear = 1'b1;
                    m_sticky = (c == N + 2) ? 0 : m_sticky & (c == N + 1);
                    if (c <= N + 1) m_sticky = 0;
                    if (c < N + 2) m_cnt = 0;
                end
            end
            if (c == N + 2 && !aborted) begin
                if (i_clear) m_cnt = 0;
                else if (eh && m_cnt < 255) m_cnt++;
            end
            if (c == rst_at) begin
                i_rst_n = 1'b0;
                aborted = 1;
                m_hit = 0; m_bound = 0; m_sticky = 0; m_ovr = 0; m_cnt = 0;
            end
        end
        @(negedge clk);
        i_frame = 1'b0;
        i_clear = 1'b0;
        i_rst_n = 1'b1;
        set_ply(s1, s2, s3, s4);
        chk("post_busy", o_busy, 0);
        chk("post_done", o_done, 0);
        chk("post_overrun", o_overrun, m_ovr);
        chk("post_sticky", o_hit_sticky, m_sticky);
`ifdef RECT_COLLIDER_HITCNT_EN
        chk("hit_cnt", o_hit_cnt, m_cnt);
`endif
    endtask

    initial begin
        int dones;
        i_rst_n = 1'b0; i_frame = 1'b0; i_clear = 1'b0;
        set_ply(0, 0, 0, 0);
        set_obs_all(300, 360, 0, 479);
        m_hit = 0; m_bound = 0; m_sticky = 0; m_ovr = 0; m_cnt = 0;
        repeat (3) @(negedge clk);
        i_rst_n = 1'b1;

        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (o_done) dones++;
        end
        chk("idle_dones", dones, 0);
        chk("idle_busy", o_busy, 0);
        chk("idle_idx", o_obs_idx, 0);
        chk("idle_hit", o_hit, 0);
        chk("idle_bound", o_bound, 0);
        chk("idle_sticky", o_hit_sticky, 0);
        chk("idle_overrun", o_overrun, 0);

        // Clear miss, then a single overlapping obstacle.
        set_ply(100, 140, 200, 230);
        run_frame(0, 0, 0);
        ox1[2] = 130; ox2[2] = 190; oy1[2] = 220; oy2[2] = 479;
        run_frame(0, 0, 0);
        pulse_clear();

        // Vertical bounds: wrapped top, bottom at the limit, just inside.
        set_obs_all(300, 360, 0, 479);
        set_ply(100, 140, 4090, 230);
        run_frame(0, 0, 0);
        set_ply(100, 140, 200, 480);
        run_frame(0, 0, 0);
        set_ply(100, 140, 200, 479);
        run_frame(0, 0, 0);

        // Wrapped obstacle is skipped; overrun mid-scan does not disturb timing.
        set_ply(100, 140, 200, 230);
        ox1[1] = 4000; ox2[1] = 20; oy1[1] = 0; oy2[1] = 479;
        run_frame(3, 0, 0);
        pulse_clear();

        // Overrun in REPORT; overrun and clear coinciding with the sticky-set edge.
        ox1[2] = 130; ox2[2] = 190; oy1[2] = 220; oy2[2] = 479;
        run_frame(N + 2, 0, 0);
        run_frame(N + 1, 1, 0);
        run_frame(N + 2, 1, 0);

        // Reset in the middle of a scan.
        run_frame(0, 0, 3);

        for (int f = 0; f < 40; f++) begin
            int x1, y1;
            for (int k = 0; k < N; k++) begin
                x1 = $urandom_range(0, 600);
                y1 = $urandom_range(0, 460);
                ox1[k] = 12'(x1); ox2[k] = 12'(x1 + $urandom_range(0, 100));
                oy1[k] = 12'(y1); oy2[k] = 12'(y1 + $urandom_range(0, 100));
                if ($urandom_range(0, 5) == 0) begin
                    ox1[k] = 12'(x1 + 120); ox2[k] = 12'(x1);
                end
            end
            x1 = $urandom_range(0, 600);
            y1 = ($urandom_range(0, 9) == 0) ? 4096 - $urandom_range(1, 20) : $urandom_range(0, 470);
            set_ply(x1, x1 + $urandom_range(0, 80), y1, (y1 + $urandom_range(0, 60)) % 4096);
            run_frame(($urandom_range(0, 3) == 0) ? $urandom_range(1, N + 2) : 0,
                      1'($urandom_range(0, 1)), 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if ($urandom_range(0, 7) == 0) pulse_clear();
        end

`ifdef RECT_COLLIDER_HITCNT_EN
        pulse_clear();
        set_obs_all(300, 360, 0, 479);
        ox1[2] = 130; ox2[2] = 190; oy1[2] = 220; oy2[2] = 479;
        set_ply(100, 140, 200, 230);
        for (int f = 0; f < 300; f++) run_frame(0, 0, 0);
        chk("hit_cnt_saturated", o_hit_cnt, 255);
        pulse_clear();
        chk("hit_cnt_cleared", o_hit_cnt, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rect_collider.md
Name: rect_collider

Overview:
- Frame-synchronous collision checker for the flappy-bird playfield.
- Consumes the edge outputs (x1/x2/y1/y2, 12-bit) of one player rectangle plus N_OBS obstacle rectangles; obstacle edges are read one at a time through an index/mux port.
- Once per frame it reports hit/boundary results to game-control logic, which freezes animation and drives the rectangle resets.

Parameters:
- N_OBS, 4, number of obstacle rectangles scanned per frame (1..15)
- D_WIDTH, 640, display width in pixels
- D_HEIGHT, 480, display height in pixels

Ports:
- i_clk  in  1  base clock
- i_rst_n  in  1  synchronous active-low reset
- i_frame  in  1  one-cycle pulse at start of vertical blank; starts a scan
- i_clear  in  1  clears the sticky flags
- i_ply_x1/i_ply_x2/i_ply_y1/i_ply_y2  in  12 each  player rectangle edges
- o_obs_idx  out  4  index of the obstacle whose edges are requested
- i_obs_x1/i_obs_x2/i_obs_y1/i_obs_y2  in  12 each  edges of obstacle o_obs_idx, valid one cycle after the index is driven
- o_busy  out  1  high while a scan is in progress
- o_done  out  1  one-cycle pulse when the frame result is valid
- o_hit  out  1  frame result: any obstacle overlap; valid with o_done, held until the next o_done
- o_bound  out  1  frame result: player out of vertical bounds; valid with o_done, held
- o_hit_sticky  out  1  set by any o_done with o_hit or o_bound; cleared by i_clear
- o_overrun  out  1  sticky: i_frame arrived while busy; cleared by i_clear

Behaviour:
- Reset (i_rst_n low at posedge): state IDLE; all outputs 0; o_obs_idx=0; internal accumulators 0.
- States:
  - IDLE: on i_frame, latch the four player edges and go to SCAN; o_obs_idx=0, o_busy=1 from the next cycle.
  - SCAN: lasts N_OBS+1 cycles.
    - With t0 = the cycle i_frame is sampled, o_obs_idx=k during cycle t0+1+k, for k=0..N_OBS-1.
    - Obstacle k edges are sampled at the end of cycle t0+2+k. o_obs_idx holds N_OBS-1 during the final sample cycle.
  - REPORT: cycle t0+N_OBS+2. o_done=1; o_hit and o_bound update; o_busy=0 in this cycle; return to IDLE.
- Latency: i_frame to o_done is N_OBS+2 cycles. With N_OBS=4, o_done appears 6 cycles after i_frame.
- Overlap rule (inclusive, unsigned 12-bit, against the latched player edges): ply_x1<=obs_x2 AND obs_x1<=ply_x2 AND ply_y1<=obs_y2 AND obs_y1<=ply_y2.
  - The hit accumulator ORs across all obstacles and is zeroed at the start of each scan.
- Degenerate obstacle: obs_x1>obs_x2 or obs_y1>obs_y2 (edge wrap past 0 or 4095) means the obstacle is skipped; it never hits.
- Boundary:
  - o_bound=1 if ply_y1[11]==1 (top edge wrapped below 0) or ply_y2>=D_HEIGHT.
  - Horizontal bounds are not checked.
  - Evaluated on the latched player edges.
- Player edges change during a scan: ignored; only the values latched at i_frame are used.
- i_frame while o_busy=1 or in REPORT: ignored, o_overrun set; the scan in progress is unaffected.
- i_frame in the same cycle as REPORT: ignored (overrun). The next scan needs a fresh i_frame in IDLE.
- i_clear with a simultaneous setting event: the set wins; the flag ends up 1.
- Reset mid-scan: aborts immediately to the IDLE reset values; no o_done is produced.

Optional Feature:
- Macro: RECT_COLLIDER_HITCNT_EN.
- With it defined:
  - Adds output o_hit_cnt (8 bits): counts REPORT cycles with o_hit=1.
  - Saturates at 255.
  - Reset to 0 by i_rst_n or i_clear; i_clear wins over a same-cycle increment.
- Without it: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then idle 10 cycles -> all outputs 0, o_obs_idx=0, no o_done.
- Player (100,140,200,230); obstacles all (300,360,0,479); i_frame -> o_obs_idx 0,1,2,3 on cycles +1..+4; o_done at +6; o_hit=0, o_bound=0.
- Same player; obstacle 2 = (130,190,220,479) -> o_hit=1, o_hit_sticky=1; i_clear -> o_hit_sticky=0.
- Player y1=4090 (wrapped), and separately player y2=480, no obstacles overlapping -> o_bound=1 at o_done in both cases. With y2=479 -> o_bound=0.
- Obstacle 1 = (4000,20,0,479) (x wrap) covering the player -> skipped, o_hit=0. Second i_frame at +3 -> o_overrun=1; o_done only at +6.
- Assert i_rst_n low at +3 of a scan -> no o_done, o_busy=0. With RECT_COLLIDER_HITCNT_EN defined, 300 hit frames -> o_hit_cnt=255.
